spinet_ring_arbiter: RTL and testbench

Round-robin transmit-slot scheduler for the SPI ring network. It grants exactly one ring node at a time permission to inject a word onto the ring. It holds that grant until the node signals completion or a timeout expires. It sits beside the ring instance, taking per-node requests and driving per-node grants, and is configured by a software-writable node enable mask.

---
 rtl/spinet_ring_arbiter_if.sv | 30 +++
 rtl/spinet_ring_arbiter.sv | 123 ++++++++++++
 tb/tb_spinet_ring_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spinet_ring_arbiter_if.sv
// Request/grant bundle between the ring nodes and the transmit-slot arbiter.
// No latency of its own; it is plain wiring.
// No backpressure; grants are held until done, timeout or mask revoke.
interface spinet_ring_arbiter_if #(
  parameter int N    = 8,
  parameter int IDXW = 3
);
  logic [N-1:0]    req;
  logic            done;
  logic            mask_we;
  logic [N-1:0]    mask_wdata;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            busy;
  logic            timeout_pulse;
  logic [N-1:0]    mask;
  logic [7:0]      tmo_count;

  // Requester / software side drives requests and mask writes.
  modport master (
    output req, done, mask_we, mask_wdata,
    input  grant, grant_idx, busy, timeout_pulse, mask, tmo_count
  );

  // Arbiter side.
  modport slave (
    input  req, done, mask_we, mask_wdata,
    output grant, grant_idx, busy, timeout_pulse, mask, tmo_count
  );
endinterface

// File: rtl/spinet_ring_arbiter.sv
// Round-robin transmit-slot scheduler granting one ring node at a time.
// Latency: grant registered one cycle after an eligible request in IDLE.
// Backpressure: grant held until done, timeout or mask clear; GAP idle cycles follow.
module spinet_ring_arbiter #(
  parameter int N       = 8,
  parameter int IDXW    = 3,
  parameter int TMOW    = 8,
  parameter int TIMEOUT = 200,
  parameter int GAP     = 2
) (
  input  logic                clk,
  input  logic                rst,
  spinet_ring_arbiter_if.slave bus
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t          state;
  logic [TMOW-1:0] timer;
  logic [GW-1:0]   gcnt;
  logic [IDXW-1:0] last;
  logic [N-1:0]    mask_q;
  logic [N-1:0]    grant_q;
  logic [IDXW-1:0] idx_q;
  logic            busy_q;
  logic            tpulse_q;
  logic [7:0]      tmo_q;

  logic [N-1:0]    elig;
  logic            pick_vld;
  logic [IDXW-1:0] pick_idx;

  assign elig = bus.req & mask_q;

  // Rotating priority scan starting just after the last winner.
  always_comb begin
    int c;
    c        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= N; i++) begin
      c = int'(last) + i;
      if (c >= N) c = c - N;
      if (!pick_vld && elig[c[IDXW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = IDXW'(c);
      end
    end
  end

  // Software-writable enable mask; arbitration this cycle still sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '1;
    end else if (bus.mask_we) begin
      mask_q <= bus.mask_wdata;
    end
  end

  // Grant FSM: pick, hold until done / timeout / mask clear, then guard gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      gcnt     <= '0;
      last     <= IDXW'(N - 1);
      grant_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      tpulse_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      tpulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            idx_q   <= pick_idx;
            busy_q  <= 1'b1;
            last    <= pick_idx;
            timer   <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          timer <= timer + TMOW'(1);
          // done and mask revoke both beat a coinciding timer expiry.
          if (bus.done || !mask_q[idx_q]) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            gcnt    <= '0;
            state   <= GUARD;
          end else if (timer == TMOW'(TIMEOUT - 1)) begin
            grant_q  <= '0;
            busy_q   <= 1'b0;
            gcnt     <= '0;
            tpulse_q <= 1'b1;
            if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
            state    <= GUARD;
          end
        end
        GUARD: begin
          if (gcnt == GW'(GAP - 1)) begin
            state <= IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_idx     = idx_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_pulse = tpulse_q;
  assign bus.mask          = mask_q;
  assign bus.tmo_count     = tmo_q;

endmodule

// File: tb/tb_spinet_ring_arbiter.sv
// Directed bench for the ring transmit-slot arbiter.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on a grant is bounded by a cycle budget.
module tb_spinet_ring_arbiter;

  localparam int TIMEOUT = 200;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  int   exp_tmo;

  spinet_ring_arbiter_if #(.N(8), .IDXW(3)) bus ();

  spinet_ring_arbiter #(
    .N(8), .IDXW(3), .TMOW(8), .TIMEOUT(TIMEOUT), .GAP(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input int budget);
    int k;
    k = 0;
    while (!bus.busy && k < budget) begin
      step(1);
      k++;
    end
    chk("grant_wait", 32'(bus.busy), 32'd1);
  endtask

  task automatic release_grant();
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
  endtask

  function automatic logic [31:0] onehot(input int idx);
    logic [7:0] one;
    one = 8'h01;
    return 32'(one << idx);
  endfunction

  int rr_exp [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int mk_exp [5] = '{4, 5, 6, 7, 4};

  initial begin
    nvec           = 0;
    nerr           = 0;
    exp_tmo        = 0;
    rst            = 1'b0;
    bus.req        = '0;
    bus.done       = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;

    // Reset values
    step(2);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_idx", 32'(bus.grant_idx), 32'h0);
    chk("rst_pulse", 32'(bus.timeout_pulse), 32'h0);
    chk("rst_mask", 32'(bus.mask), 32'hFF);
    chk("rst_tmo", 32'(bus.tmo_count), 32'h0);
    rst = 1'b1;
    step(1);

    // Single request: one-cycle latency, hold after req drop, done revoke, guard gap
    bus.req = 8'h01;
    step(1);
    chk("first_grant", 32'(bus.grant), 32'h01);
    chk("first_busy", 32'(bus.busy), 32'h1);
    chk("first_idx", 32'(bus.grant_idx), 32'h0);
    bus.req = 8'h00;
    step(1);
    chk("hold_no_req", 32'(bus.grant), 32'h01);
    release_grant();
    chk("done_revoke", 32'(bus.grant), 32'h0);
    chk("done_busy", 32'(bus.busy), 32'h0);
    bus.req = 8'h01;
    step(1);
    chk("guard1", 32'(bus.grant), 32'h0);
    step(1);
    chk("guard2", 32'(bus.grant), 32'h0);
    step(1);
    chk("after_guard", 32'(bus.grant), 32'h01);
    release_grant();
    bus.req = 8'h00;

    // Round robin from a fresh reset with all nodes requesting
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      wait_grant(8);
      chk("rr_idx", 32'(bus.grant_idx), 32'(rr_exp[k]));
      chk("rr_grant", 32'(bus.grant), onehot(rr_exp[k]));
      step(1);
      release_grant();
      chk("rr_revoke", 32'(bus.busy), 32'h0);
    end

    // Timeout on node 2 (last winner is 0, only node 2 requests)
    bus.req = 8'h04;
    wait_grant(8);
    chk("tmo_idx", 32'(bus.grant_idx), 32'h2);
    step(TIMEOUT - 1);
    chk("tmo_hold", 32'(bus.busy), 32'h1);
    chk("tmo_nopulse_yet", 32'(bus.timeout_pulse), 32'h0);
    step(1);
    chk("tmo_revoke", 32'(bus.busy), 32'h0);
    chk("tmo_pulse", 32'(bus.timeout_pulse), 32'h1);
    chk("tmo_count1", 32'(bus.tmo_count), 32'h1);
    exp_tmo = 1;
    step(1);
    chk("tmo_pulse_end", 32'(bus.timeout_pulse), 32'h0);

    // done coinciding with timer expiry: done wins
    wait_grant(8);
    step(TIMEOUT - 1);
    release_grant();
    chk("tie_busy", 32'(bus.busy), 32'h0);
    chk("tie_pulse", 32'(bus.timeout_pulse), 32'h0);
    chk("tie_count", 32'(bus.tmo_count), 32'h1);

    // Mask 0xF0: only nodes 4..7 granted
    bus.req = 8'h00;
    step(3);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 8'hF0;
    step(1);
    bus.mask_we    = 1'b0;
    chk("mask_rd", 32'(bus.mask), 32'hF0);
    bus.req = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(8);
      chk("mask_idx", 32'(bus.grant_idx), 32'(mk_exp[k]));
      step(1);
      release_grant();
    end

    // Clear the active node's mask bit mid-grant
    wait_grant(8);
    chk("mclr_idx", 32'(bus.grant_idx), 32'h5);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 8'hD0;
    step(1);
    bus.mask_we    = 1'b0;
    chk("mclr_still", 32'(bus.busy), 32'h1);
    step(1);
    chk("mclr_revoke", 32'(bus.busy), 32'h0);
    chk("mclr_pulse", 32'(bus.timeout_pulse), 32'h0);
    chk("mclr_count", 32'(bus.tmo_count), 32'h1);
    wait_grant(8);
    chk("mclr_next", 32'(bus.grant_idx), 32'h6);
    release_grant();

    // Saturate the timeout counter
    bus.req        = 8'h00;
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 8'hFF;
    step(1);
    bus.mask_we    = 1'b0;
    bus.req        = 8'h04;
    for (int k = 0; k < 299; k++) begin
      wait_grant(8);
      step(TIMEOUT);
      exp_tmo = (exp_tmo == 255) ? 255 : exp_tmo + 1;
      chk("sat_pulse", 32'(bus.timeout_pulse), 32'h1);
      chk("sat_count", 32'(bus.tmo_count), 32'(exp_tmo));
    end

    // Asynchronous reset in the middle of a grant to node 5
    bus.req = 8'h20;
    wait_grant(8);
    chk("mid_idx", 32'(bus.grant), 32'h20);
    #2;
    rst = 1'b0;
    #1;
    chk("async_grant", 32'(bus.grant), 32'h0);
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_tmo", 32'(bus.tmo_count), 32'h0);
    bus.req = 8'hFF;
    @(negedge clk);
    rst = 1'b1;
    step(1);
    chk("post_rst_grant", 32'(bus.grant), 32'h01);
    chk("post_rst_idx", 32'(bus.grant_idx), 32'h0);
    chk("post_rst_mask", 32'(bus.mask), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
